// File: rtl/ps2_key_event_rx_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 key-event receiver.
//   - prefix byte values (E0 extended, F0 break) and the extended arrow codes
//   - frame-state enum for the bit-level receiver FSM
//   - key_event_t payload stored in the event FIFO
//   - odd-parity check helper
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam logic [7:0] PS2_KEY_UP    = 8'h75;
  localparam logic [7:0] PS2_KEY_DOWN  = 8'h72;
  localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_event_rx_fifo.sv
// ps2_event_fifo: show-ahead FIFO of key events.
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   i_push, i_data : enqueue request and payload
//   i_pop          : dequeue request (ignored when empty)
//   o_valid        : head entry present
//   o_data         : head entry, read combinationally from registered storage
//   o_count        : occupancy (0..DEPTH)
//   o_drop         : push refused because the FIFO was full and not popping
// DEPTH must be a power of two so the pointers wrap naturally.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  key_event_t               i_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output key_event_t               o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  key_event_t       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  logic empty_s;
  logic full_s;
  logic pop_ok_s;
  logic push_ok_s;

  assign empty_s   = (count_q == '0);
  assign full_s    = (count_q == FULL_CNT);
  assign pop_ok_s  = i_pop & ~empty_s;
  // A pop on the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok_s = i_push & (~full_s | pop_ok_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_valid = ~empty_s;
  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_drop  = i_push & ~push_ok_s;

endmodule

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: PS/2 keyboard receiver running entirely on i_clk.
// Oversamples the PS/2 lines, decodes 11-bit frames, folds E0/F0 prefixes
// into single key events and queues them in a show-ahead FIFO.
//   i_clk, i_rst_n            : system clock, asynchronous active-low reset
//   i_ps2_clk, i_ps2_data     : raw asynchronous PS/2 lines
//   o_valid, i_ready          : event handshake at the FIFO head
//   o_code, o_ext, o_release  : head event fields
//   o_count                   : FIFO occupancy
//   o_frame_err, o_overflow   : sticky error flags, cleared by i_clear_err
//   o_arrows                  : {up,down,left,right} held state
// Optional feature macro: KEY_STATE_EN enables o_arrows tracking; otherwise
// o_arrows is tied to zero.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_ps2_clk,
  input  logic                          i_ps2_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [7:0]                    o_code,
  output logic                          o_ext,
  output logic                          o_release,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_frame_err,
  output logic                          o_overflow,
  input  logic                          i_clear_err,
  output logic [3:0]                    o_arrows
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  // Synchronisers reset to 1: both PS/2 lines idle high, so no false edge.
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall_s;

  frame_state_e state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic         parity_q, parity_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic         timeout_s;
  logic         byte_valid_s;
  logic         frame_bad_s;

  logic         ext_q, ext_d;
  logic         rel_q, rel_d;
  logic         emit_s;
  key_event_t   event_s;

  logic         frame_err_d;
  logic         overflow_d;
  logic         drop_s;
  key_event_t   head_s;

  // Two-flop (or deeper) synchronisers and previous-clock register for edge detect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], i_ps2_data};
      clk_prev_q  <= clk_s;
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall_s = clk_prev_q & ~clk_s;

  // Watchdog fires only mid-frame and never on a cycle that carries an edge.
  assign timeout_s = (state_q != ST_IDLE) && !fall_s && (wdog_q == WD_LAST);

  // Watchdog next-state: held at zero in IDLE, reloaded on each PS/2 edge.
  always_comb begin
    if (fall_s || (state_q == ST_IDLE)) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + WDW'(1);
    end
  end

  // Frame FSM next-state: start / 8 data LSB-first / parity / stop checks.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    byte_valid_s = 1'b0;
    frame_bad_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A high data level on an edge is a glitch, not a start bit.
        if (fall_s && !data_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (timeout_s) begin
          state_d     = ST_IDLE;
          frame_bad_s = 1'b1;
        end else if (fall_s) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (timeout_s) begin
          state_d     = ST_IDLE;
          frame_bad_s = 1'b1;
        end else if (fall_s) begin
          parity_d = data_s;
          state_d  = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (timeout_s) begin
          state_d     = ST_IDLE;
          frame_bad_s = 1'b1;
        end else if (fall_s) begin
          state_d = ST_IDLE;
          if (data_s && odd_parity_ok(shift_q, parity_q)) begin
            byte_valid_s = 1'b1;
          end else begin
            frame_bad_s = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Prefix decoder: E0/F0 only set flags; any other byte becomes an event.
  always_comb begin
    ext_d  = ext_q;
    rel_d  = rel_q;
    emit_s = 1'b0;
    if (frame_bad_s) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (byte_valid_s) begin
      if (shift_q == PS2_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PS2_PREFIX_BRK) begin
        rel_d = 1'b1;
      end else begin
        emit_s = 1'b1;
        ext_d  = 1'b0;
        rel_d  = 1'b0;
      end
    end else begin
      ext_d = ext_q;
      rel_d = rel_q;
    end
  end

  assign event_s = {ext_q, rel_q, shift_q};

  // Sticky flags: a new error in the same cycle as a clear keeps the flag set.
  always_comb begin
    frame_err_d = frame_bad_s | (o_frame_err & ~i_clear_err);
    overflow_d  = drop_s | (o_overflow & ~i_clear_err);
  end

  // Frame FSM, watchdog, prefix flags and sticky error registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      wdog_q      <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      o_frame_err <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      wdog_q      <= wdog_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      o_frame_err <= frame_err_d;
      o_overflow  <= overflow_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (emit_s),
    .i_data  (event_s),
    .i_pop   (i_ready),
    .o_valid (o_valid),
    .o_data  (head_s),
    .o_count (o_count),
    .o_drop  (drop_s)
  );

  assign o_code    = head_s.code;
  assign o_ext     = head_s.ext;
  assign o_release = head_s.rel;

`ifdef KEY_STATE_EN
  logic [3:0] arrows_q, arrows_d;

  // Arrow held-state: only extended events touch it, regardless of FIFO space.
  always_comb begin
    arrows_d = arrows_q;
    if (emit_s && ext_q) begin
      case (shift_q)
        PS2_KEY_UP:    arrows_d[3] = ~rel_q;
        PS2_KEY_DOWN:  arrows_d[2] = ~rel_q;
        PS2_KEY_LEFT:  arrows_d[1] = ~rel_q;
        PS2_KEY_RIGHT: arrows_d[0] = ~rel_q;
        default:       arrows_d    = arrows_q;
      endcase
    end else begin
      arrows_d = arrows_q;
    end
  end

  // Arrow held-state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      arrows_q <= 4'b0000;
    end else begin
      arrows_q <= arrows_d;
    end
  end

  assign o_arrows = arrows_q;
`else
  assign o_arrows = 4'b0000;
`endif

endmodule

// File: doc/ps2_key_event_rx.md
Name: ps2_key_event_rx

Overview:
PS/2 keyboard receiver clocked entirely in the system domain. It oversamples the PS/2 clock and data lines and decodes full 11-bit frames. It folds the E0 (extended) and F0 (break) prefixes into single key events and buffers those events in a FIFO with a valid/ready output. It replaces ad-hoc PS/2-clock-domain receivers and feeds game/UI control logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages on i_ps2_clk and i_ps2_data (min 2)
FIFO_DEPTH, 8, event FIFO entries (power of 2, >= 2)
TIMEOUT_CYCLES, 50000, i_clk cycles without a PS/2 falling edge before a partial frame is abandoned (>= 16)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_ps2_clk  in  1  raw PS/2 clock (async)
i_ps2_data  in  1  raw PS/2 data (async)
o_valid  out  1  event available at FIFO head
i_ready  in  1  consumer accepts head event
o_code  out  8  scan code of head event
o_ext  out  1  head event had E0 prefix
o_release  out  1  head event had F0 prefix (key up)
o_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
o_frame_err  out  1  sticky: start/parity/stop/timeout error seen
o_overflow  out  1  sticky: event dropped because FIFO full
i_clear_err  in  1  one-cycle pulse; clears both sticky flags
o_arrows  out  4  {up,down,left,right} held state (KEY_STATE_EN only; else tied 0)

Behaviour:
- Reset (async, any state): FSM IDLE, prefix flags 0, FIFO empty, o_valid=0, o_code=0, o_ext=0, o_release=0, o_count=0, sticky flags 0, o_arrows=0. A partial frame is discarded.
- Sync: both lines pass through SYNC_STAGES flops. A PS/2 falling edge is synced-clk previous=1 and current=0. Data is sampled on that same cycle.
- Frame FSM states IDLE, DATA, PARITY, STOP:
  - IDLE: on an edge with data=0 (start bit) go to DATA and set bit_cnt=0. Data=1 on an edge is ignored (glitch).
  - DATA: shift in 8 bits LSB-first. After bit 7 go to PARITY.
  - PARITY: capture the bit, then go to STOP.
  - STOP: frame is good only if data=1 and XOR(data[7:0], parity)=1 (odd parity). A good frame produces a one-cycle byte_valid strobe. A bad frame sets o_frame_err and the byte is discarded. Return to IDLE in either case.
- Timeout: in any state other than IDLE, a watchdog counts i_clk cycles since the last edge. At TIMEOUT_CYCLES it returns the FSM to IDLE and sets o_frame_err. The watchdog reloads on every edge.
- Prefix decoder, on byte_valid:
  - E0 sets ext.
  - F0 sets rel.
  - Any other byte emits event {ext, rel, byte} and clears both flags.
  - Prefix bytes are never enqueued.
  - Both flags also clear on frame error or timeout.
- FIFO:
  - Push on emit. Pop when o_valid & i_ready.
  - Output is show-ahead: o_code/o_ext/o_release reflect the head entry combinationally from registered storage. Head fields hold when o_valid=0.
  - Latency: emit on cycle N makes o_valid=1 on cycle N+1 if the FIFO was empty.
  - Full and push (no pop): new event dropped, o_overflow=1.
  - Full with simultaneous push and pop: both succeed, count unchanged.
  - Empty with pop request: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- i_clear_err coincident with a new error: the error wins (flag stays 1).

Optional Feature:
KEY_STATE_EN:
- Defined: o_arrows tracks held extended arrow keys E0 75 (up), E0 72 (down), E0 6B (left), E0 74 (right).
  - A make event sets its bit; a break event clears it.
  - Updated on the emit cycle, independent of FIFO full.
  - Non-extended 75/72/6B/74 (keypad) do not affect o_arrows.
- Undefined: no state logic; o_arrows=4'b0.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, arrow codes 8'h75/8'h72/8'h6B/8'h74;
  - frame-state enum;
  - typedef key_event_t packed {ext, rel, code[7:0]}.
- One sub-module: ps2_event_fifo (parameterised by depth, key_event_t payload, count output). The frame FSM, watchdog and decoder stay in the top.

Test Plan:
- Send frame 0x1C (start 0, LSB-first, parity 0, stop 1) at 12.5 kHz PS/2 clock -> one event code=1C, ext=0, rel=0, o_valid rises one cycle after stop, o_count=1.
- Send E0 F0 75 with i_ready=0 -> exactly one event code=75, ext=1, rel=1, o_count=1. With KEY_STATE_EN: E0 75 sets o_arrows=4'b1000, then E0 F0 75 returns it to 0000.
- Send 0x1C with wrong parity bit -> no event, o_frame_err=1. Pulse i_clear_err -> 0. Next good frame decodes normally.
- Stop PS/2 clock after 4 data bits for TIMEOUT_CYCLES+1 cycles -> o_frame_err=1, FSM IDLE. Following full frame 0x29 decodes as 29.
- i_ready=0, send FIFO_DEPTH+1 make codes 0x01..0x09 (depth 8) -> o_count=8, o_overflow=1. Drain yields 01..08 in order and 09 is lost. Push+pop on the same cycle when full keeps o_count=8.
- Assert i_rst_n low mid-frame (after bit 3) -> all outputs 0 immediately. After release, a fresh frame 0x5A decodes correctly.
